host_uart_rsp_serializer: RTL and testbench

Takes a fully built host response frame (up to 128 bytes, byte 0 in bits [7:0]) from the response encoder and streams it byte-by-byte to the UART transmitter over a valid/ready byte handshake. Each frame goes out wrapped as sync byte, length byte, payload and an 8-bit checksum. The block sits between the host response encoder and the UART TX shifter, and decouples wide-word frame construction from byte-rate transmission with backpressure.

---
 rtl/host_uart_pkg.sv | 26 ++
 rtl/host_uart_cksum.sv | 39 +++
 rtl/host_uart_rsp_serializer.sv | 180 ++++++++++++++++++
 tb/tb_host_uart_rsp_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/host_uart_pkg.sv
// Shared constants, state encoding and response IDs for the host UART path.
package host_uart_pkg;

    localparam int          MAX_BYTES = 128;
    localparam int          IDX_W     = 7;
    localparam logic [7:0]  MAX_LEN   = 8'(MAX_BYTES);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // Host response IDs carried in payload byte 0
    localparam logic [7:0]  RSP_ID_ENC_ENABLE = 8'h02;
    localparam logic [7:0]  RSP_ID_READ_YAW   = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CKSUM
    } ser_state_e;

    // A frame must carry at least one payload byte and fit the latch register
    function automatic logic len_is_legal(input logic [7:0] len);
        return (len != 8'd0) && (len <= MAX_LEN);
    endfunction

endpackage

// File: rtl/host_uart_cksum.sv
// 8-bit running sum with synchronous clear and accumulate enable.
// sum_next_o previews sum_o + din_i so a caller can emit the final sum
// in the same cycle the last byte is accumulated.
module host_uart_cksum (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       acc_en_i,
    input  logic [7:0] din_i,
    output logic [7:0] sum_o,
    output logic [7:0] sum_next_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // Next-sum selection: clear wins over accumulate
    always_comb begin
        sum_next_o = sum_q + din_i;
        sum_d      = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (acc_en_i) begin
            sum_d = sum_next_o;
        end
    end

    // Sum register
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/host_uart_rsp_serializer.sv
// Streams a latched host response frame to the UART TX as
// SYNC, LEN, payload bytes, checksum over a valid/ready byte handshake.
// Every output is registered; tx_ready only steers next-state logic.
module host_uart_rsp_serializer
    import host_uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MAX_BYTES*8-1:0] frame_data,
    input  logic [7:0]             frame_len,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    ser_state_e             state_q, state_d;
    logic [MAX_BYTES*8-1:0] frame_q, frame_d;
    logic [7:0]             len_q, len_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   ck_clr;
    logic                   ck_en;
    logic [7:0]             ck_din;
    logic [7:0]             ck_sum;
    logic [7:0]             ck_sum_next;

    logic                   xfer;
    logic [IDX_W-1:0]       idx_inc;
    logic [IDX_W+2:0]       cur_off;
    logic [IDX_W+2:0]       next_off;
    logic [7:0]             cur_byte;
    logic [7:0]             next_byte;
    logic                   is_last;

    host_uart_cksum u_cksum (
        .clk        (clk),
        .reset_i    (reset),
        .clr_i      (ck_clr),
        .acc_en_i   (ck_en),
        .din_i      (ck_din),
        .sum_o      (ck_sum),
        .sum_next_o (ck_sum_next)
    );

    // Byte offsets into the latched frame for the current and following payload byte
    always_comb begin
        xfer      = tx_valid_q && tx_ready;
        idx_inc   = idx_q + 1'b1;
        cur_off   = {idx_q, 3'b000};
        next_off  = {idx_inc, 3'b000};
        cur_byte  = frame_q[cur_off +: 8];
        next_byte = frame_q[next_off +: 8];
        is_last   = ({1'b0, idx_q} == (len_q - 8'd1));
    end

    // Next-state and registered-output logic; the byte to offer next is
    // loaded into tx_data on the same edge that completes the current transfer
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        len_d      = len_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        ck_clr     = 1'b0;
        ck_en      = 1'b0;
        ck_din     = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_is_legal(frame_len)) begin
                        frame_d    = frame_data;
                        len_d      = frame_len;
                        idx_d      = '0;
                        ck_clr     = 1'b1;
                        tx_data_d  = SYNC_BYTE;
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = ST_SYNC;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (xfer) begin
                    tx_data_d = len_q;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    ck_en     = 1'b1;
                    ck_din    = len_q;
                    tx_data_d = frame_q[7:0];
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    ck_en  = 1'b1;
                    ck_din = cur_byte;
                    if (is_last) begin
                        tx_data_d = ck_sum_next;
                        state_d   = ST_CKSUM;
                    end else begin
                        idx_d     = idx_inc;
                        tx_data_d = next_byte;
                    end
                end
            end
            ST_CKSUM: begin
                if (xfer) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    idx_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Frame latch; contents are only meaningful once a start is accepted
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        len_q   <= len_d;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

    // ck_sum is observed through sum_next_o; keep the registered view tied off
    logic unused_ck_sum;
    assign unused_ck_sum = ^ck_sum;

endmodule

// File: tb/tb_host_uart_rsp_serializer.sv
// Directed, table-driven bench for host_uart_rsp_serializer.
module tb_host_uart_rsp_serializer;
    import host_uart_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [MAX_BYTES*8-1:0] frame_data;
    logic [7:0]             frame_len;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    logic                   done;
    logic                   error;

    host_uart_rsp_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_data (frame_data),
        .frame_len  (frame_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]             len;
        logic [MAX_BYTES*8-1:0] data;
        logic [7:0]             cksum;          // hand-computed expected checksum
        int                     stall_at;       // transfer index to stall on, -1 none
        int                     stall_cycles;
        int                     busy_start_cyc; // cycle to pulse a start while busy, 0 none
    } vec_t;

    vec_t                   vecs[5];
    vec_t                   v_one;
    logic [MAX_BYTES*8-1:0] alt_data;
    int                     checks;
    int                     failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int k);
        int n;
        n = int'(v.len);
        if (k == 0)           return 8'hA5;
        else if (k == 1)      return v.len;
        else if (k <= n + 1)  return v.data[(k-2)*8 +: 8];
        else                  return v.cksum;
    endfunction

    // Called at a negedge; issues start, streams the frame, checks done timing.
    // Returns at the negedge where done is high, so the next call is back-to-back.
    task automatic run_frame(input vec_t v, input int id);
        int  k;
        int  cyc;
        int  stall_left;
        int  total;
        logic done_early;
        total      = int'(v.len) + 3;
        k          = 0;
        cyc        = 0;
        stall_left = v.stall_cycles;
        done_early = 1'b0;
        frame_data = v.data;
        frame_len  = v.len;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (k < total && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (v.busy_start_cyc != 0 && cyc == v.busy_start_cyc) begin
                start      = 1'b1;
                frame_data = alt_data;
                frame_len  = 8'd12;
            end else begin
                start = 1'b0;
            end
            if (k == v.stall_at && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = 1'b1;
            end
            if (done) done_early = 1'b1;
            chk($sformatf("f%0d_valid_k%0d", id, k), 32'(tx_valid), 32'd1);
            chk($sformatf("f%0d_busy_k%0d", id, k), 32'(busy), 32'd1);
            chk($sformatf("f%0d_data_k%0d", id, k), 32'(tx_data), 32'(exp_byte(v, k)));
            if (tx_valid && tx_ready) k++;
        end
        chk($sformatf("f%0d_timeout", id), 32'(k), 32'(total));
        tx_ready = 1'b1;
        start    = 1'b0;
        @(negedge clk);
        cyc++;
        chk($sformatf("f%0d_done", id), 32'(done), 32'd1);
        chk($sformatf("f%0d_busy_end", id), 32'(busy), 32'd0);
        chk($sformatf("f%0d_valid_end", id), 32'(tx_valid), 32'd0);
        chk($sformatf("f%0d_error", id), 32'(error), 32'd0);
        chk($sformatf("f%0d_done_early", id), 32'(done_early), 32'd0);
        chk($sformatf("f%0d_done_cycle", id), 32'(cyc), 32'(total + 1 + v.stall_cycles));
        $display("frame %0d len=%0d transfers=%0d done_cycle=%0d", id, v.len, k, cyc);
    endtask

    task automatic illegal_start(input logic [7:0] len);
        frame_len = len;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk($sformatf("ill%0d_error", len), 32'(error), 32'd1);
        chk($sformatf("ill%0d_busy", len), 32'(busy), 32'd0);
        chk($sformatf("ill%0d_valid", len), 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("ill%0d_error_clr", len), 32'(error), 32'd0);
        chk($sformatf("ill%0d_valid2", len), 32'(tx_valid), 32'd0);
        $display("illegal start len=%0d error=%0b busy=%0b", len, error, busy);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        tx_ready   = 1'b1;
        frame_len  = 8'd0;
        frame_data = '0;

        // Response frames
        alt_data = '0;
        alt_data[7:0] = RSP_ID_READ_YAW;
        alt_data[8*7 +: 8] = 8'h78;
        alt_data[8*8 +: 8] = 8'h56;
        alt_data[8*9 +: 8] = 8'h34;
        alt_data[8*10 +: 8] = 8'h12;
        alt_data[8*11 +: 8] = 8'h01;

        vecs[0].len = 8'd8;  vecs[0].data = '0; vecs[0].data[7:0] = RSP_ID_ENC_ENABLE;
        vecs[0].cksum = 8'h0A; vecs[0].stall_at = -1; vecs[0].stall_cycles = 0; vecs[0].busy_start_cyc = 0;

        vecs[1].len = 8'd12; vecs[1].data = alt_data;
        vecs[1].cksum = 8'h25; vecs[1].stall_at = -1; vecs[1].stall_cycles = 0; vecs[1].busy_start_cyc = 0;

        vecs[2] = vecs[1];
        vecs[2].stall_at = 1; vecs[2].stall_cycles = 3;

        vecs[3] = vecs[0];
        vecs[3].busy_start_cyc = 4;

        vecs[4].len = 8'd128; vecs[4].data = '0;
        for (int i = 0; i < 128; i++) vecs[4].data[i*8 +: 8] = 8'(i);
        vecs[4].cksum = 8'h40; vecs[4].stall_at = 130; vecs[4].stall_cycles = 2; vecs[4].busy_start_cyc = 0;

        v_one.len = 8'd1; v_one.data = '0; v_one.data[7:0] = 8'hFF;
        v_one.cksum = 8'h00; v_one.stall_at = -1; v_one.stall_cycles = 0; v_one.busy_start_cyc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(tx_valid), 32'd0);

        // Illegal lengths
        illegal_start(8'd0);
        illegal_start(8'd129);

        // Table-driven frames, back-to-back
        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        // Reset while payload byte 3 of a read-yaw frame is offered
        frame_data = alt_data;
        frame_len  = 8'd12;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_pre_valid", 32'(tx_valid), 32'd1);
        chk("midrst_pre_data", 32'(tx_data), 32'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_data", 32'(tx_data), 32'h00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst_done_%0d", i), 32'(done), 32'd0);
            chk($sformatf("postrst_valid_%0d", i), 32'(tx_valid), 32'd0);
        end
        $display("reset mid-frame tx_valid=%0b busy=%0b", tx_valid, busy);

        run_frame(v_one, 5);
        @(negedge clk);
        chk("final_done_clr", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
